// File: rtl/debounce_timer_arbiter_pkg.sv
// Shared definitions for the shared-timer pushbutton debouncer.
//   btn_state_t            : per-button FSM encoding (3-bit)
//   DEFAULT_CNT_WIDTH      : default width of the shared wait counter
//   DEFAULT_MAX_CLK_COUNT  : default terminal count (40 ms at 12 MHz)
package debounce_timer_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_HIGH    = 3'd0,
      ST_LOW     = 3'd1,
      ST_PENDING = 3'd2,
      ST_WAIT    = 3'd3,
      ST_PRESSED = 3'd4
   } btn_state_t;

   localparam int              DEFAULT_CNT_WIDTH     = 20;
   localparam logic [19:0]     DEFAULT_MAX_CLK_COUNT = 20'd480000 - 20'd1;

endpackage

// File: rtl/debounce_timer_arbiter_fsm.sv
// Per-button debounce state machine. Detects a press edge, requests the
// shared timer, and after the wait re-samples the button to validate it.
//   clk, rst     : clock, synchronous active-high reset
//   inc          : button asserted (already inverted from active-low pad)
//   grant        : arbiter grants the shared timer to this button
//   timer_done   : shared counter reached its terminal value
//   req          : this button is waiting for the timer
//   in_wait      : this button currently owns the timer
//   press_pulse  : single-cycle validated press
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_HIGH    | released or held after a press; waits for inc == 0
// ST_LOW     | armed; waits for a press edge (inc == 1)
// ST_PENDING | press seen; requesting the timer, inc ignored
// ST_WAIT    | owns the timer; inc sampled only at terminal count
// ST_PRESSED | press validated; emits one pulse
module btn_debounce_fsm
   import debounce_timer_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic grant,
   input  logic timer_done,
   output logic req,
   output logic in_wait,
   output logic press_pulse
);

   btn_state_t state, state_nxt;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_HIGH;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      req         = 1'b0;
      in_wait     = 1'b0;
      press_pulse = 1'b0;
      case (state)
         ST_HIGH:    if (!inc) state_nxt = ST_LOW;
         ST_LOW:     if (inc)  state_nxt = ST_PENDING;
         ST_PENDING: begin
            req = 1'b1;
            if (grant) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            in_wait = 1'b1;
            if (timer_done) state_nxt = inc ? ST_PRESSED : ST_HIGH;
         end
         ST_PRESSED: begin
            press_pulse = 1'b1;
            state_nxt   = ST_HIGH;
         end
         default:    state_nxt = ST_HIGH;
      endcase
   end

endmodule

// File: rtl/debounce_timer_arbiter.sv
// Debounces NUM_BTNS active-low pushbuttons with one shared wait timer.
// A round-robin arbiter hands the timer to one pending button at a time.
//   clk          : system clock
//   rst          : synchronous active-high reset
//   btn_n        : raw pushbuttons, active-low
//   press_pulse  : one-cycle pulse per validated press
//   timer_busy   : some button is in its wait phase
//   timer_owner  : index of the current or last timer owner
module debounce_timer_arbiter
   import debounce_timer_arbiter_pkg::*;
#(
   parameter int                   NUM_BTNS      = 4,
   parameter int                   CNT_WIDTH     = DEFAULT_CNT_WIDTH,
   parameter logic [CNT_WIDTH-1:0] MAX_CLK_COUNT = CNT_WIDTH'(DEFAULT_MAX_CLK_COUNT)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_BTNS-1:0]         btn_n,
   output logic [NUM_BTNS-1:0]         press_pulse,
   output logic                        timer_busy,
   output logic [$clog2(NUM_BTNS)-1:0] timer_owner
);

   localparam int OW_W = $clog2(NUM_BTNS);

   logic [NUM_BTNS-1:0]  inc;
   logic [NUM_BTNS-1:0]  req;
   logic [NUM_BTNS-1:0]  in_wait;
   logic [NUM_BTNS-1:0]  grant;
   logic [CNT_WIDTH-1:0] count;
   logic                 timer_done;
   logic [OW_W-1:0]      ptr;
   logic [OW_W-1:0]      ptr_nxt;
   logic [OW_W-1:0]      winner;
   logic [OW_W-1:0]      scan_idx;
   logic                 found;
   logic                 grant_any;

   assign inc        = ~btn_n;
   assign timer_busy = |in_wait;
   assign timer_done = (count == MAX_CLK_COUNT);

   for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
      btn_debounce_fsm u_fsm (
         .clk         (clk),
         .rst         (rst),
         .inc         (inc[g]),
         .grant       (grant[g]),
         .timer_done  (timer_done),
         .req         (req[g]),
         .in_wait     (in_wait[g]),
         .press_pulse (press_pulse[g])
      );
   end

   // Scan upward from ptr with wrap; first pending index wins.
   always_comb begin
      winner   = '0;
      scan_idx = '0;
      found    = 1'b0;
      for (int k = 0; k < NUM_BTNS; k++) begin
         scan_idx = OW_W'((int'(ptr) + k) % NUM_BTNS);
         if (!found && req[scan_idx]) begin
            found  = 1'b1;
            winner = scan_idx;
         end
      end
      // Granting only while the timer is idle guarantees a single owner.
      grant_any = found && !timer_busy;
      grant     = '0;
      if (grant_any) grant[winner] = 1'b1;
      ptr_nxt   = OW_W'((int'(winner) + 1) % NUM_BTNS);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count       <= '0;
         ptr         <= '0;
         timer_owner <= '0;
      end else if (grant_any) begin
         count       <= '0;
         ptr         <= ptr_nxt;
         timer_owner <= winner;
      end else if (timer_busy && !timer_done) begin
         count       <= count + CNT_WIDTH'(1);
      end else begin
         count       <= '0;
      end
   end

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
module tb_debounce_timer_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] btn_n;
   logic [3:0] press_pulse;
   logic       timer_busy;
   logic [1:0] timer_owner;

   int n_checks = 0;
   int n_errors = 0;

   debounce_timer_arbiter #(
      .NUM_BTNS      (4),
      .CNT_WIDTH     (20),
      .MAX_CLK_COUNT (20'd3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_n       (btn_n),
      .press_pulse (press_pulse),
      .timer_busy  (timer_busy),
      .timer_owner (timer_owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges; afterwards we sit 1 time unit into the new cycle.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   int         pulse_cnt;
   logic [3:0] pulse_or;
   logic       busy_or;

   initial begin
      rst   = 1'b1;
      btn_n = 4'hF;
      tick(2);
      chk("rst_pulse", 32'(press_pulse), 32'h0);
      chk("rst_busy",  32'(timer_busy),  32'h0);
      chk("rst_owner", 32'(timer_owner), 32'h0);
      rst = 1'b0;
      tick(3);

      // Clean press on btn0 in cycle c.
      btn_n = 4'b1110;
      tick(1);
      chk("t1_c1_busy",  32'(timer_busy),  32'h0);
      tick(1);
      chk("t1_c2_busy",  32'(timer_busy),  32'h1);
      chk("t1_c2_owner", 32'(timer_owner), 32'h0);
      tick(3);
      chk("t1_c5_busy",  32'(timer_busy),  32'h1);
      chk("t1_c5_pulse", 32'(press_pulse), 32'h0);
      tick(1);
      chk("t1_c6_pulse", 32'(press_pulse), 32'h1);
      chk("t1_c6_busy",  32'(timer_busy),  32'h0);
      tick(1);
      chk("t1_c7_pulse", 32'(press_pulse), 32'h0);
      btn_n = 4'hF;
      tick(3);

      // Bouncy btn1: released at terminal count, no pulse.
      btn_n = 4'b1101;
      tick(1);
      btn_n = 4'b1111;
      tick(1);
      chk("t2_c2_busy",  32'(timer_busy),  32'h1);
      chk("t2_c2_owner", 32'(timer_owner), 32'h1);
      btn_n = 4'b1101;
      tick(3);
      btn_n = 4'b1111;
      chk("t2_c5_busy",  32'(timer_busy),  32'h1);
      tick(1);
      chk("t2_c6_pulse", 32'(press_pulse), 32'h0);
      chk("t2_c6_busy",  32'(timer_busy),  32'h0);
      tick(1);
      chk("t2_c7_pulse", 32'(press_pulse), 32'h0);

      rst = 1'b1;
      tick(1);
      chk("rst2_owner", 32'(timer_owner), 32'h0);
      rst = 1'b0;
      tick(3);

      // Simultaneous btn0 and btn2.
      btn_n = 4'b1010;
      tick(2);
      chk("t3_c2_owner", 32'(timer_owner), 32'h0);
      chk("t3_c2_busy",  32'(timer_busy),  32'h1);
      tick(4);
      chk("t3_c6_pulse", 32'(press_pulse), 32'h1);
      chk("t3_c6_busy",  32'(timer_busy),  32'h0);
      tick(1);
      chk("t3_c7_busy",  32'(timer_busy),  32'h1);
      chk("t3_c7_owner", 32'(timer_owner), 32'h2);
      chk("t3_c7_pulse", 32'(press_pulse), 32'h0);
      tick(4);
      chk("t3_c11_pulse", 32'(press_pulse), 32'h4);
      tick(1);
      chk("t3_c12_pulse", 32'(press_pulse), 32'h0);
      chk("t3_c12_busy",  32'(timer_busy),  32'h0);
      btn_n = 4'hF;
      tick(3);

      // Fairness: pointer is 3, so btn3 beats btn0.
      btn_n = 4'b0110;
      tick(2);
      chk("t4_c2_owner", 32'(timer_owner), 32'h3);
      tick(4);
      chk("t4_c6_pulse", 32'(press_pulse), 32'h8);
      tick(1);
      chk("t4_c7_owner", 32'(timer_owner), 32'h0);
      chk("t4_c7_busy",  32'(timer_busy),  32'h1);
      tick(4);
      chk("t4_c11_pulse", 32'(press_pulse), 32'h1);
      btn_n = 4'hF;
      tick(3);

      // Reset in the middle of btn1's wait.
      btn_n = 4'b1101;
      tick(2);
      chk("t5_c2_owner", 32'(timer_owner), 32'h1);
      tick(1);
      rst = 1'b1;
      tick(1);
      chk("t5_c4_pulse", 32'(press_pulse), 32'h0);
      chk("t5_c4_busy",  32'(timer_busy),  32'h0);
      chk("t5_c4_owner", 32'(timer_owner), 32'h0);
      rst      = 1'b0;
      pulse_or = '0;
      busy_or  = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         pulse_or |= press_pulse;
         busy_or  |= timer_busy;
      end
      chk("t5_held_pulse", 32'(pulse_or), 32'h0);
      chk("t5_held_busy",  32'(busy_or),  32'h0);
      btn_n = 4'hF;
      tick(2);
      btn_n = 4'b1101;
      tick(6);
      chk("t5_repress_pulse", 32'(press_pulse), 32'h2);
      tick(1);
      btn_n = 4'hF;
      tick(3);

      // Long hold on btn3 yields one pulse; re-press yields another.
      btn_n     = 4'b0111;
      pulse_cnt = 0;
      pulse_or  = '0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         pulse_cnt += int'(press_pulse[3]);
         pulse_or  |= press_pulse;
      end
      chk("t6_hold_cnt",   32'(pulse_cnt), 32'h1);
      chk("t6_hold_other", 32'(pulse_or),  32'h8);
      btn_n = 4'hF;
      tick(3);
      btn_n     = 4'b0111;
      pulse_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         pulse_cnt += int'(press_pulse[3]);
      end
      chk("t6_second_cnt", 32'(pulse_cnt), 32'h1);
      btn_n = 4'hF;
      tick(3);
      chk("idle_pulse", 32'(press_pulse), 32'h0);
      chk("idle_busy",  32'(timer_busy),  32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
